ym3012_rx: RTL and testbench

- Downstream consumer of the k053260 DAC serial output (SY, SH1, SH2, SO), i.e. the YM3012-side stage.
- Samples the serial floating-point stream in the CLK domain.
- Converts each 13-bit float word (10-bit mantissa, 3-bit exponent) to a 16-bit signed linear sample per channel.
- Emits one-cycle valid strobes. Used by benches and by the FPGA audio path in place of the external DAC.

---
 rtl/ym3012_pkg.sv | 18 +
 rtl/fp_to_lin.sv | 22 ++
 rtl/ym3012_rx.sv | 93 +++++++++
 tb/tb_ym3012_rx.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym3012_pkg.sv
// ym3012_pkg: shared constants and the float word layout for the YM3012-side
// receiver. The float word is {exp, mant}, taken from SR[15:3] of the serial
// shift register; SR[2:0] carry no information.
package ym3012_pkg;

  localparam int unsigned MANT_W        = 10;
  localparam int unsigned EXP_W         = 3;
  localparam int unsigned WORD_LSB_SKIP = 3;
  localparam int unsigned FLOAT_W       = MANT_W + EXP_W;
  localparam int unsigned SR_W          = WORD_LSB_SKIP + FLOAT_W;
  localparam int unsigned LIN_W         = 16;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_word_t;

endpackage

// File: rtl/fp_to_lin.sv
// fp_to_lin: combinational 13-bit float to 16-bit signed linear converter.
//   word : {exp[2:0], mant[9:0]}, mant is two's complement
//   lin  : 0 when exp == 0, else sign_extend(mant) << (exp - 1)
// Range is -32768..+32704, so no saturation is required.
module fp_to_lin
  import ym3012_pkg::*;
(
  input  fp_word_t          word,
  output logic [LIN_W-1:0]  lin
);

  logic [LIN_W-1:0] mant_ext;

  always_comb begin
    mant_ext = {{(LIN_W-MANT_W){word.mant[MANT_W-1]}}, word.mant};
    lin      = '0;
    if (word.exp != '0) begin
      lin = mant_ext << (word.exp - 1'b1);
    end
  end

endmodule

// File: rtl/ym3012_rx.sv
// ym3012_rx: receiver for the k053260 DAC serial stream, sampled in CLK.
//   CLK        system clock
//   nRES       synchronous active-low reset
//   SY         serial bit clock (CLK/2); a rising SY edge is a bit tick
//   SH1/SH2    left/right word latch, falling edge seen on a bit tick
//   SO         serial data, LSB first
//   L/R        signed linear samples, updated one CLK after a latch tick
//   L_VALID/R_VALID  one-CLK update strobes
//   FRAME_ERR  one-CLK strobe: latch seen with bit count != FRAME_BITS
module ym3012_rx
  import ym3012_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned OUT_W      = 16
) (
  input  logic             CLK,
  input  logic             nRES,
  input  logic             SY,
  input  logic             SH1,
  input  logic             SH2,
  input  logic             SO,
  output logic [OUT_W-1:0] L,
  output logic [OUT_W-1:0] R,
  output logic             L_VALID,
  output logic             R_VALID,
  output logic             FRAME_ERR
);

  localparam logic [4:0] CNT_MAX   = 5'd31;
  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

  // Only SR[15:3] are ever observed, so SR[2:0] are not stored; the bits
  // simply fall off the end of the register instead.
  logic [SR_W-1:WORD_LSB_SKIP] sr;
  logic                        sy_q;
  logic [4:0]                  bit_cnt;
  logic                        sh1_t;
  logic                        sh2_t;

  logic             tick;
  logic             latch1;
  logic             latch2;
  logic [LIN_W-1:0] lin;

  assign tick   = ~sy_q & SY;
  assign latch1 = tick & sh1_t & ~SH1;
  assign latch2 = tick & sh2_t & ~SH2;

  // Both channels latch from the same shift register, so one converter
  // serves both; it sees SR before the current tick's shift.
  fp_to_lin u_conv (
    .word (fp_word_t'(sr)),
    .lin  (lin)
  );

  always_ff @(posedge CLK) begin
    if (!nRES) begin
      sy_q      <= 1'b1;
      sr        <= '0;
      bit_cnt   <= '0;
      sh1_t     <= 1'b0;
      sh2_t     <= 1'b0;
      L         <= '0;
      R         <= '0;
      L_VALID   <= 1'b0;
      R_VALID   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      sy_q      <= SY;
      L_VALID   <= latch1;
      R_VALID   <= latch2;
      FRAME_ERR <= (latch1 | latch2) && (bit_cnt != FRAME_CNT);
      if (latch1) begin
        L <= lin;
      end
      if (latch2) begin
        R <= lin;
      end
      if (tick) begin
        sr    <= {SO, sr[SR_W-1:WORD_LSB_SKIP+1]};
        sh1_t <= SH1;
        sh2_t <= SH2;
        // The latch tick's own bit belongs to the next frame.
        if (latch1 | latch2) begin
          bit_cnt <= 5'd1;
        end else if (bit_cnt != CNT_MAX) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ym3012_rx.sv
// tb_ym3012_rx: self-checking bench for ym3012_rx. A behavioural model keeps
// the received bit history, the previous SH levels and the ticks since the
// last latch, and derives expected samples with plain integer arithmetic.
module tb_ym3012_rx;

  logic        CLK  = 1'b0;
  logic        nRES = 1'b0;
  logic        SY   = 1'b1;
  logic        SH1  = 1'b0;
  logic        SH2  = 1'b0;
  logic        SO   = 1'b0;
  logic [15:0] L;
  logic [15:0] R;
  logic        L_VALID;
  logic        R_VALID;
  logic        FRAME_ERR;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic        q_bits[$];
  int unsigned m_cnt;
  logic        m_sh1_t;
  logic        m_sh2_t;
  logic [15:0] m_l;
  logic [15:0] m_r;
  logic        g_lv;
  logic        g_rv;
  logic        g_fe;
  int unsigned fe_seen;
  logic        chain_open;

  ym3012_rx #(.FRAME_BITS(16), .OUT_W(16)) dut (
    .CLK       (CLK),
    .nRES      (nRES),
    .SY        (SY),
    .SH1       (SH1),
    .SH2       (SH2),
    .SO        (SO),
    .L         (L),
    .R         (R),
    .L_VALID   (L_VALID),
    .R_VALID   (R_VALID),
    .FRAME_ERR (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Last 16 received bits, newest at bit 15; never-received bits read as 0.
  function automatic logic [15:0] model_word();
    logic [15:0] w;
    int n;
    w = '0;
    n = q_bits.size();
    for (int k = 0; k < 16; k++) begin
      if (n - 16 + k >= 0) w[k] = q_bits[n - 16 + k];
    end
    return w;
  endfunction

  function automatic logic [15:0] f2l(input logic [15:0] w);
    int m;
    int e;
    m = int'(w[12:3]);
    if (m >= 512) m = m - 1024;
    e = int'(w[15:13]);
    if (e == 0) return 16'h0000;
    return 16'(m * (1 << (e - 1)));
  endfunction

  function automatic logic [15:0] mk_word(input int unsigned m, input int unsigned e);
    logic [9:0] mm;
    logic [2:0] ee;
    mm = 10'(m);
    ee = 3'(e);
    return {ee, mm, 3'($urandom)};
  endfunction

  task automatic model_reset();
    q_bits.delete();
    m_cnt      = 0;
    m_sh1_t    = 1'b0;
    m_sh2_t    = 1'b0;
    m_l        = '0;
    m_r        = '0;
    chain_open = 1'b0;
  endtask

  // One bit tick: SY low for a cycle, then high; outputs are checked right
  // after the tick edge and the strobes again one cycle later.
  task automatic do_tick(input logic so, input logic s1, input logic s2);
    logic [15:0] w;
    logic e1;
    logic e2;
    logic fe;
    SO = so; SH1 = s1; SH2 = s2; SY = 1'b0;
    @(posedge CLK); #1;
    SY = 1'b1;
    @(posedge CLK); #1;
    w  = model_word();
    e1 = m_sh1_t & ~s1;
    e2 = m_sh2_t & ~s2;
    fe = (e1 | e2) && (m_cnt != 16);
    if (e1) m_l = f2l(w);
    if (e2) m_r = f2l(w);
    if (e1 | e2) m_cnt = 1;
    else if (m_cnt < 31) m_cnt = m_cnt + 1;
    q_bits.push_back(so);
    if (q_bits.size() > 16) void'(q_bits.pop_front());
    m_sh1_t = s1;
    m_sh2_t = s2;
    g_lv = L_VALID; g_rv = R_VALID; g_fe = FRAME_ERR;
    if (FRAME_ERR === 1'b1) fe_seen++;
    n_checks++;
    if ({L_VALID, R_VALID, FRAME_ERR} !== {e1, e2, fe}) begin
      n_err++;
      $display("FAIL tick_strobes: got LV/RV/FE=%b expected %b", {L_VALID, R_VALID, FRAME_ERR}, {e1, e2, fe});
    end
    n_checks++;
    if (L !== m_l) begin
      n_err++;
      $display("FAIL tick_L: got %h expected %h", L, m_l);
    end
    n_checks++;
    if (R !== m_r) begin
      n_err++;
      $display("FAIL tick_R: got %h expected %h", R, m_r);
    end
    @(posedge CLK); #1;
    n_checks++;
    if ({L_VALID, R_VALID, FRAME_ERR} !== 3'b000) begin
      n_err++;
      $display("FAIL strobe_width: got LV/RV/FE=%b expected 000", {L_VALID, R_VALID, FRAME_ERR});
    end
  endtask

  // Frame of n ticks: the first tick has both SH low (it may be the latch
  // tick of the previous frame), the rest hold the selected SH high.
  task automatic send_frame(input logic [15:0] w, input logic a1, input logic a2, input int unsigned n);
    logic b;
    for (int unsigned i = (chain_open ? 1 : 0); i < n; i++) begin
      if (i < 16) b = w[i];
      else b = 1'($urandom);
      if (i == 0) do_tick(b, 1'b0, 1'b0);
      else do_tick(b, a1, a2);
    end
    chain_open = 1'b0;
  endtask

  // Latch tick for whatever frame is open; it also starts the next frame.
  task automatic close_frame();
    do_tick(1'($urandom), 1'b0, 1'b0);
    chain_open = 1'b1;
  endtask

  task automatic test_reset();
    nRES = 1'b0; SO = 1'b1; SH1 = 1'b1; SH2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SY = (i % 2 == 1);
      @(posedge CLK); #1;
      n_checks++;
      if ({L, R} !== 32'h0) begin
        n_err++;
        $display("FAIL reset_LR: got %h/%h expected 0000/0000", L, R);
      end
      n_checks++;
      if ({L_VALID, R_VALID, FRAME_ERR} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_strobes: got %b expected 000", {L_VALID, R_VALID, FRAME_ERR});
      end
    end
    SH1 = 1'b0; SH2 = 1'b0;
    nRES = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if ({L_VALID, R_VALID, FRAME_ERR} !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset_strobes: got %b expected 000", {L_VALID, R_VALID, FRAME_ERR});
    end
    model_reset();
  endtask

  task automatic test_basic_left();
    send_frame(mk_word(10'h001, 1), 1'b1, 1'b0, 16);
    close_frame();
    n_checks++;
    if ({g_lv, g_rv, g_fe} !== 3'b100) begin
      n_err++;
      $display("FAIL basic_strobes: got %b expected 100", {g_lv, g_rv, g_fe});
    end
    n_checks++;
    if (L !== 16'h0001 || R !== 16'h0000) begin
      n_err++;
      $display("FAIL basic_LR: got %h/%h expected 0001/0000", L, R);
    end
  endtask

  task automatic test_full_scale();
    send_frame(mk_word(10'h1FF, 7), 1'b0, 1'b1, 16);
    close_frame();
    n_checks++;
    if (R !== 16'h7FC0 || {g_lv, g_rv} !== 2'b01) begin
      n_err++;
      $display("FAIL full_pos: got R=%h LV/RV=%b expected 7fc0 01", R, {g_lv, g_rv});
    end
    send_frame(mk_word(10'h200, 7), 1'b0, 1'b1, 16);
    close_frame();
    n_checks++;
    if (R !== 16'h8000) begin
      n_err++;
      $display("FAIL full_neg: got R=%h expected 8000", R);
    end
  endtask

  task automatic test_sign();
    send_frame(mk_word(10'h3FF, 0), 1'b1, 1'b0, 16);
    close_frame();
    n_checks++;
    if (L !== 16'h0000 || g_lv !== 1'b1) begin
      n_err++;
      $display("FAIL silence: got L=%h LV=%b expected 0000 1", L, g_lv);
    end
    send_frame(mk_word(10'h3FF, 3), 1'b1, 1'b0, 16);
    close_frame();
    n_checks++;
    if (L !== 16'hFFFC) begin
      n_err++;
      $display("FAIL neg_sign: got L=%h expected fffc", L);
    end
  endtask

  task automatic test_short_frame();
    send_frame(mk_word(10'h055, 4), 1'b1, 1'b0, 16);
    close_frame();
    send_frame(mk_word(10'h123, 5), 1'b1, 1'b0, 12);
    fe_seen = 0;
    close_frame();
    n_checks++;
    if ({g_lv, g_fe} !== 2'b11 || fe_seen != 1) begin
      n_err++;
      $display("FAIL short_frame: got LV/FE=%b count=%0d expected 11 count=1", {g_lv, g_fe}, fe_seen);
    end
    send_frame(mk_word(10'h0AA, 2), 1'b1, 1'b0, 16);
    fe_seen = 0;
    close_frame();
    n_checks++;
    if (g_fe !== 1'b0 || fe_seen != 0 || L !== 16'h0154) begin
      n_err++;
      $display("FAIL after_short: got FE=%b count=%0d L=%h expected 0 0 0154", g_fe, fe_seen, L);
    end
  endtask

  task automatic test_saturate();
    // 48 ticks: a saturating counter reads 31, a wrapping one would read 16.
    send_frame(mk_word(10'h011, 1), 1'b1, 1'b0, 48);
    close_frame();
    n_checks++;
    if ({g_lv, g_fe} !== 2'b11) begin
      n_err++;
      $display("FAIL saturate: got LV/FE=%b expected 11", {g_lv, g_fe});
    end
  endtask

  task automatic test_simultaneous();
    send_frame(mk_word(10'h100, 2), 1'b1, 1'b1, 16);
    close_frame();
    n_checks++;
    if (L !== 16'h0200 || R !== 16'h0200 || {g_lv, g_rv, g_fe} !== 3'b110) begin
      n_err++;
      $display("FAIL simultaneous: got L=%h R=%h LV/RV/FE=%b expected 0200 0200 110", L, R, {g_lv, g_rv, g_fe});
    end
  endtask

  task automatic test_sy_stuck();
    for (int i = 0; i < 26; i++) begin
      SY  = (i < 20);
      SH1 = 1'($urandom);
      SH2 = 1'($urandom);
      SO  = 1'($urandom);
      @(posedge CLK); #1;
      n_checks++;
      if ({L_VALID, R_VALID, FRAME_ERR} !== 3'b000 || L !== m_l || R !== m_r) begin
        n_err++;
        $display("FAIL sy_stuck: got %b L=%h R=%h expected 000 L=%h R=%h", {L_VALID, R_VALID, FRAME_ERR}, L, R, m_l, m_r);
      end
    end
    SH1 = 1'b0; SH2 = 1'b0;
  endtask

  task automatic test_random();
    logic a1;
    logic a2;
    int unsigned n;
    for (int it = 0; it < 30; it++) begin
      a1 = 1'($urandom);
      a2 = 1'($urandom);
      n  = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 24) : 16;
      send_frame(16'($urandom), a1, a2, n);
      close_frame();
    end
  endtask

  task automatic test_midframe_reset();
    send_frame(mk_word(10'h155, 6), 1'b1, 1'b1, 16);
    // Would-be latch tick arrives while reset is asserted.
    SO = 1'b1; SH1 = 1'b0; SH2 = 1'b0; SY = 1'b0;
    @(posedge CLK); #1;
    SY = 1'b1; nRES = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if ({L, R} !== 32'h0 || {L_VALID, R_VALID, FRAME_ERR} !== 3'b000) begin
        n_err++;
        $display("FAIL mid_reset: got L=%h R=%h %b expected 0000 0000 000", L, R, {L_VALID, R_VALID, FRAME_ERR});
      end
    end
    nRES = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if ({L_VALID, R_VALID, FRAME_ERR} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_reset_release: got %b expected 000", {L_VALID, R_VALID, FRAME_ERR});
    end
    model_reset();
    send_frame(mk_word(10'h07F, 1), 1'b1, 1'b0, 16);
    close_frame();
    n_checks++;
    if (L !== 16'h007F || R !== 16'h0000 || {g_lv, g_fe} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_recover: got L=%h R=%h LV/FE=%b expected 007f 0000 10", L, R, {g_lv, g_fe});
    end
  endtask

  initial begin
    model_reset();
    fe_seen = 0;
    test_reset();
    test_basic_left();
    test_full_scale();
    test_sign();
    test_short_frame();
    test_saturate();
    test_simultaneous();
    test_sy_stuck();
    test_random();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
